// File: rtl/rs_ff_bank.sv
// Bank of independent registered RS flops, all updated on the same edge, with a configurable S=R=1 action.
// Also registers change pulses, sticky conflict flags and a popcount of the state; reset is asynchronous.
module rs_ff_bank #(
   parameter int               WIDTH   = 8,
   parameter int               MODE    = 0,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [WIDTH-1:0]           S,
   input  logic [WIDTH-1:0]           R,
   input  logic                       clr_conf,
   output logic [WIDTH-1:0]           Q,
   output logic [WIDTH-1:0]           Qbar,
   output logic [WIDTH-1:0]           chg,
   output logic [WIDTH-1:0]           conf,
   output logic [$clog2(WIDTH+1)-1:0] ones
);

   localparam int CW = $clog2(WIDTH+1);

   function automatic logic [CW-1:0] popcnt(input logic [WIDTH-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < WIDTH; i++) begin
         c = c + CW'(v[i]);
      end
      return c;
   endfunction

   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] chg_q, chg_d;
   logic [WIDTH-1:0] conf_q, conf_d;
   logic [CW-1:0]    ones_q, ones_d;

   always_comb begin
      q_d = q_q;
      if (en) begin
         for (int i = 0; i < WIDTH; i++) begin
            unique case ({S[i], R[i]})
               2'b00: q_d[i] = q_q[i];
               2'b10: q_d[i] = 1'b1;
               2'b01: q_d[i] = 1'b0;
               2'b11: begin
                  // Unlisted MODE values fall back to hold.
                  case (MODE)
                     1:       q_d[i] = 1'b1;
                     2:       q_d[i] = 1'b0;
                     3:       q_d[i] = ~q_q[i];
                     default: q_d[i] = q_q[i];
                  endcase
               end
            endcase
         end
      end
      chg_d  = q_d ^ q_q;
      // A conflict seen on this edge beats a simultaneous clear.
      conf_d = (clr_conf ? '0 : conf_q) | ({WIDTH{en}} & S & R);
      ones_d = popcnt(q_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q    <= RST_VAL;
         chg_q  <= '0;
         conf_q <= '0;
         ones_q <= popcnt(RST_VAL);
      end else begin
         q_q    <= q_d;
         chg_q  <= chg_d;
         conf_q <= conf_d;
         ones_q <= ones_d;
      end
   end

   assign Q    = q_q;
   assign Qbar = ~q_q;
   assign chg  = chg_q;
   assign conf = conf_q;
   assign ones = ones_q;

endmodule

// File: tb/tb_rs_ff_bank.sv
// Drives one shared stimulus stream into eight differently parameterised banks and
// scoreboards every output against a per-channel behavioural model.
module tb_rs_ff_bank;

   localparam int ND    = 8;
   localparam int NSTEP = 400;
   localparam int          WID [ND] = '{8, 8, 8, 8, 8, 1, 32, 8};
   localparam int          MD  [ND] = '{0, 1, 2, 3, 0, 0, 0, 5};
   localparam logic [31:0] RV  [ND] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hA5, 32'h0, 32'h0, 32'h3C};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        clr_conf = 1'b0;
   logic [31:0] s_drv = '0;
   logic [31:0] r_drv = '0;

   logic [31:0] q_w [ND];
   logic [31:0] qb_w [ND];
   logic [31:0] chg_w [ND];
   logic [31:0] conf_w [ND];
   logic [31:0] ones_w [ND];

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      localparam int W  = WID[g];
      localparam int CW = $clog2(W+1);
      localparam logic [W-1:0] RVAL = RV[g][W-1:0];
      logic [W-1:0]  q_l, qb_l, chg_l, conf_l;
      logic [CW-1:0] ones_l;
      rs_ff_bank #(.WIDTH(W), .MODE(MD[g]), .RST_VAL(RVAL)) u_dut (
         .clk      (clk),
         .rst      (rst),
         .en       (en),
         .S        (s_drv[W-1:0]),
         .R        (r_drv[W-1:0]),
         .clr_conf (clr_conf),
         .Q        (q_l),
         .Qbar     (qb_l),
         .chg      (chg_l),
         .conf     (conf_l),
         .ones     (ones_l)
      );
      assign q_w[g]    = 32'(q_l);
      assign qb_w[g]   = 32'(qb_l);
      assign chg_w[g]  = 32'(chg_l);
      assign conf_w[g] = 32'(conf_l);
      assign ones_w[g] = 32'(ones_l);
   end

   typedef struct packed {
      logic [ND-1:0][31:0] q;
      logic [ND-1:0][31:0] chg;
      logic [ND-1:0][31:0] conf;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] m_q [ND];
   logic [31:0] m_chg [ND];
   logic [31:0] m_conf [ND];
   int          vec_cnt = 0;
   int          miss_cnt = 0;
   int          nstep = 0;

   function automatic logic [31:0] mask_of(input int w);
      return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
   endfunction

   // One window: apply inputs just after an edge, publish what the outputs must
   // show until the next edge, then advance the model across that next edge.
   task automatic step(input logic e, input logic rs, input logic cl,
                       input logic [31:0] s, input logic [31:0] r);
      exp_t        x;
      logic [31:0] mk, qn;
      @(posedge clk);
      #1;
      en = e; rst = rs; clr_conf = cl; s_drv = s; r_drv = r;
      for (int d = 0; d < ND; d++) begin
         if (rs) begin
            m_q[d]    = RV[d] & mask_of(WID[d]);
            m_chg[d]  = '0;
            m_conf[d] = '0;
         end
         x.q[d]    = m_q[d];
         x.chg[d]  = m_chg[d];
         x.conf[d] = m_conf[d];
      end
      exp_q.push_back(x);
      if (!rs) begin
         for (int d = 0; d < ND; d++) begin
            mk = mask_of(WID[d]);
            qn = m_q[d];
            if (e) begin
               for (int i = 0; i < WID[d]; i++) begin
                  if (s[i] && !r[i])      qn[i] = 1'b1;
                  else if (!s[i] && r[i]) qn[i] = 1'b0;
                  else if (s[i] && r[i]) begin
                     if (MD[d] == 1)      qn[i] = 1'b1;
                     else if (MD[d] == 2) qn[i] = 1'b0;
                     else if (MD[d] == 3) qn[i] = ~m_q[d][i];
                  end
               end
            end
            m_chg[d]  = qn ^ m_q[d];
            m_conf[d] = ((cl ? 32'h0 : m_conf[d]) | (e ? (s & r & mk) : 32'h0));
            m_q[d]    = qn;
         end
      end
      nstep++;
   endtask

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] req);
      vec_cnt++;
      if (act !== req) begin
         miss_cnt++;
         $display("FAIL %s dut%0d step%0d actual=%h required=%h", nm, d, vec_cnt, act, req);
      end
   endtask

   task automatic monitor();
      exp_t x;
      repeat (NSTEP) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0) begin
            vec_cnt++;
            miss_cnt++;
            $display("FAIL scoreboard_empty actual=0 required=1");
         end else begin
            x = exp_q.pop_front();
            for (int d = 0; d < ND; d++) begin
               chk("Q",    d, q_w[d],    x.q[d]);
               chk("Qbar", d, qb_w[d],   ~x.q[d] & mask_of(WID[d]));
               chk("chg",  d, chg_w[d],  x.chg[d]);
               chk("conf", d, conf_w[d], x.conf[d]);
               chk("ones", d, ones_w[d], 32'($countones(x.q[d])));
            end
         end
      end
   endtask

   task automatic driver();
      logic        e, rs, cl;
      logic [31:0] s, r;
      step(0, 1, 0, 32'h0, 32'h0);
      step(0, 1, 0, 32'h0, 32'h0);
      // Truth table
      step(1, 0, 0, 32'h01, 32'h00);
      step(1, 0, 0, 32'h00, 32'h00);
      step(1, 0, 0, 32'h00, 32'h01);
      step(1, 0, 0, 32'h00, 32'h00);
      // Conflict on channel 0 for three edges, then clear
      step(1, 0, 0, 32'h01, 32'h01);
      step(1, 0, 0, 32'h01, 32'h01);
      step(1, 0, 0, 32'h01, 32'h01);
      step(1, 0, 0, 32'h00, 32'h00);
      step(1, 0, 1, 32'h00, 32'h00);
      step(1, 0, 0, 32'h00, 32'h00);
      // Enable gating
      step(1, 0, 0, 32'hF0, 32'h0F);
      step(0, 0, 0, 32'h0F, 32'hF0);
      step(0, 0, 0, 32'h0F, 32'hF0);
      step(0, 0, 0, 32'h0F, 32'hF0);
      step(1, 0, 0, 32'h0F, 32'hF0);
      step(1, 0, 0, 32'h00, 32'h00);
      // Mid-cycle reset, then recovery from the reset value
      step(1, 0, 0, 32'h3C, 32'hC3);
      step(1, 0, 0, 32'h00, 32'h00);
      step(1, 1, 0, 32'h00, 32'h00);
      step(1, 0, 0, 32'h02, 32'h00);
      step(1, 0, 0, 32'h00, 32'h00);
      // Clear colliding with a new conflict
      step(1, 0, 1, 32'h80, 32'h80);
      step(1, 0, 1, 32'h00, 32'h00);
      step(1, 0, 0, 32'h00, 32'h00);
      // Clear while disabled
      step(1, 0, 0, 32'h55, 32'h55);
      step(0, 0, 1, 32'hFF, 32'hFF);
      step(1, 0, 0, 32'hFFFF_FFFF, 32'h0);
      step(1, 0, 0, 32'h0, 32'h0);
      while (nstep < NSTEP) begin
         e  = ($urandom_range(3) != 0);
         rs = ($urandom_range(39) == 0);
         cl = ($urandom_range(7) == 0);
         s  = $urandom;
         r  = ($urandom_range(1) != 0) ? $urandom : (s ^ ($urandom & $urandom));
         step(e, rs, cl, s, r);
      end
   endtask

   initial begin
      for (int d = 0; d < ND; d++) begin
         m_q[d]    = RV[d] & mask_of(WID[d]);
         m_chg[d]  = '0;
         m_conf[d] = '0;
      end
      fork
         driver();
         monitor();
      join
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
